// File: rtl/debounce8_if.sv
// debounce8_if: raw board inputs and conditioned level/edge outputs of debounce8.
interface debounce8_if;
    logic [7:0] raw, stable, rise, fall;
    modport master (output raw, input stable, rise, fall);
    modport slave (input raw, output stable, rise, fall);
endinterface

// File: rtl/debounce8.sv
// debounce8: 8-channel 2-flop synchroniser and debouncer; define DEBOUNCE8_EDGE_EN for rise/fall pulses.
module debounce8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [7:0]  INIT_VAL        = 8'h00
) (
    input logic        clk,
    input logic        rst_n,
    debounce8_if.slave bus
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);
    logic [7:0] s1_q, s2_q, stable_q, stable_d;
    logic [7:0][CW-1:0] cnt_q, cnt_d;
    // A channel counts only while its synchronised input disagrees with its level.
    always_comb begin
        cnt_d = '0;
        stable_d = stable_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] != TC) ? cnt_q[i] + 1'b1 : '0;
            stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == TC) ? s2_q[i] : stable_q[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= INIT_VAL;
            s2_q <= INIT_VAL;
            stable_q <= INIT_VAL;
            cnt_q <= '0;
        end else begin
            s1_q <= bus.raw;
            s2_q <= s1_q;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
        end
    end
    assign bus.stable = stable_q;
`ifdef DEBOUNCE8_EDGE_EN
    logic [7:0] rise_q, fall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= stable_d & ~stable_q;
            fall_q <= ~stable_d & stable_q;
        end
    end
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`else
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif
endmodule

// File: tb/tb_debounce8.sv
// tb_debounce8: scoreboard bench for debounce8 (default 16-cycle instance and a 1-cycle instance).
module tb_debounce8;
    typedef struct {
        int         c;
        logic [7:0] st, ri, fa;
        string      nm;
    } exp_t;

    logic clk = 0, rst_n = 0;
    int   cyc = 0, tests = 0, fails = 0;
    exp_t qa[$], qb[$];

    debounce8_if ifa ();
    debounce8_if ifb ();
    debounce8 #(.DEBOUNCE_CYCLES(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    debounce8 #(.DEBOUNCE_CYCLES(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input bit b, input int c, input logic [7:0] st, ri, fa, input string nm);
        exp_t e;
        e.c = c; e.st = st; e.ri = ri; e.fa = fa; e.nm = nm;
`ifndef DEBOUNCE8_EDGE_EN
        e.ri = 8'h00; e.fa = 8'h00;
`endif
        if (b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic check(input exp_t e, input logic [7:0] st, ri, fa);
        tests++;
        if (e.c != cyc || st !== e.st || ri !== e.ri || fa !== e.fa) begin
            fails++;
            $display("FAIL %s @%0d: got stable=%h rise=%h fall=%h, expected stable=%h rise=%h fall=%h (due @%0d)",
                     e.nm, cyc, st, ri, fa, e.st, e.ri, e.fa, e.c);
        end
    endtask

    always @(negedge clk) begin
        while (qa.size() != 0 && qa[0].c <= cyc) check(qa.pop_front(), ifa.stable, ifa.rise, ifa.fall);
        while (qb.size() != 0 && qb[0].c <= cyc) check(qb.pop_front(), ifb.stable, ifb.rise, ifb.fall);
    end

    // Stable change is due 18 negedge-samples after the raw change (k = n+1, update at k+17).
    task automatic change_a(input logic [7:0] v, old, input string nm);
        int n;
        n = cyc;
        ifa.raw = v;
        push(0, n + 17, old, 8'h00, 8'h00, {nm, "_pre"});
        push(0, n + 18, v, v & ~old, ~v & old, nm);
        push(0, n + 19, v, 8'h00, 8'h00, {nm, "_post"});
        repeat (20) @(negedge clk);
    endtask

    task automatic change_b(input logic [7:0] v, old, input string nm);
        int n;
        n = cyc;
        ifb.raw = v;
        push(1, n + 2, old, 8'h00, 8'h00, {nm, "_pre"});
        push(1, n + 3, v, v & ~old, ~v & old, nm);
        push(1, n + 4, v, 8'h00, 8'h00, {nm, "_post"});
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int c;
        ifa.raw = 8'h00;
        ifb.raw = 8'h00;
        push(0, 1, 8'h00, 8'h00, 8'h00, "reset_a");
        push(1, 1, 8'h00, 8'h00, 8'h00, "reset_b");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        change_a(8'h01, 8'h00, "press");
        for (int i = 0; i < 100; i++) begin
            ifa.raw = (i % 8 < 5) ? 8'h09 : 8'h01;
            push(0, cyc + 1, 8'h01, 8'h00, 8'h00, "bounce");
            @(negedge clk);
        end
        ifa.raw = 8'h01;
        for (int i = 0; i < 20; i++) begin
            push(0, cyc + 1, 8'h01, 8'h00, 8'h00, "bounce_hold");
            @(negedge clk);
        end
        change_a(8'h00, 8'h01, "release");
        change_a(8'hA5, 8'h00, "indep_a5");
        change_a(8'h5A, 8'hA5, "indep_5a");
        change_b(8'h80, 8'h00, "d1_rise");
        change_b(8'h00, 8'h80, "d1_fall");
        ifa.raw = 8'hFF;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        push(0, cyc, 8'h00, 8'h00, 8'h00, "rst_async");
        @(negedge clk);
        #2 rst_n = 1;
        c = cyc;
        push(0, c + 17, 8'h00, 8'h00, 8'h00, "rst_pre");
        push(0, c + 18, 8'hFF, 8'hFF, 8'h00, "rst_after");
        push(0, c + 19, 8'hFF, 8'h00, 8'h00, "rst_post");
        repeat (22) @(negedge clk);
        #1;
        if (qa.size() + qb.size() != 0) begin
            fails += qa.size() + qb.size();
            $display("FAIL drain: %0d expectations never checked, required 0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debounce8.md
# debounce8

Eight-channel input conditioner that synchronises and debounces eight raw, asynchronous board inputs (switches/buttons) into eight clean, glitch-free level bits. It is the front-end stage that feeds the `or8way` "any input active" detector and other basic-logic consumers on the FPGA. It optionally produces single-cycle rise and fall event pulses per channel.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a level change is accepted. Legal values are 1 to 65535.
- `INIT_VAL`, default 8'h00: value of all internal state and of `stable` after reset.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; assertion takes effect immediately; deassertion is synchronous to `clk` at board level.
- `raw`  input  8  asynchronous raw inputs; bit i is channel i.
- `stable`  output  8  debounced level per channel.
- `rise`  output  8  one-cycle pulse per channel when `stable[i]` goes 0→1.
- `fall`  output  8  one-cycle pulse per channel when `stable[i]` goes 1→0.

## Operation
- Each channel is fully independent: a 2-flop synchroniser (`s1[i]`, `s2[i]`), a counter `cnt[i]` of width max(1, $clog2(DEBOUNCE_CYCLES)), and a `stable[i]` register.
- Each channel has two states, IDLE (`s2[i] == stable[i]`, `cnt[i] == 0`) and COUNTING (`s2[i] != stable[i]`). The rules on each edge are:
  - `s2[i] == stable[i]`: `cnt[i]` is set to 0. Any pending change is discarded, so a bounce shorter than DEBOUNCE_CYCLES is rejected.
  - `s2[i] != stable[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i]` increments.
  - `s2[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i]` takes `s2[i]` and `cnt[i]` is set to 0.
- The counter never wraps, because it is cleared at terminal count.
- `rise[i]` and `fall[i]` are registered. They are high for exactly the one cycle in which `stable[i]` first shows its new value. They are never both high on the same channel.
- A simultaneous change on several channels produces simultaneous, independent updates and pulses.
- With DEBOUNCE_CYCLES = 1 the block is a pure 2-flop synchroniser plus a 1-cycle register.

## Timing
- Reset values: `s1`, `s2` and `stable` are INIT_VAL; every `cnt` is 0; `rise` and `fall` are 8'h00.
  - No pulses are generated on reset release, even if `raw` differs from INIT_VAL. The debounce then proceeds normally.
- Latency:
  - Let edge k be the first edge that samples the new `raw[i]` value into `s1[i]`, with `raw[i]` held steady from then on.
  - `stable[i]`, and the matching pulse, change at edge k+1+DEBOUNCE_CYCLES.
  - For example, with the default of 16 the change appears 17 edges after k.
- Rejection: a change that is held for fewer than DEBOUNCE_CYCLES cycles of `s2` leaves `stable` unchanged.
- Reset mid-count: every counter and register returns to its reset value immediately. No pulse is generated.
- No handshake: `stable` is a level output and is valid every cycle.

## Configuration
- `DEBOUNCE8_EDGE_EN` defined: the `rise` and `fall` registers and logic are compiled in and behave as specified above.
- Undefined: `rise` and `fall` are tied to 8'h00 and no edge registers are synthesised. The `stable` behaviour is identical.

## Test plan
- Clean press, DEBOUNCE_CYCLES=16, macro defined: `raw` goes 8'h00→8'h01 and is held. `stable[0]` must go to 1 exactly 17 edges after the first sampling edge, `rise` must be 8'h01 for one cycle, and `fall` must stay 0.
- Bounce rejection: `raw[3]` is toggled with high periods of 5 cycles and low periods of 3 cycles for 100 cycles, then held low. `stable` must stay 8'h00 and `rise`/`fall` must stay 0 throughout.
- Independent channels: `raw` goes 8'h00→8'hA5 and is held, then later goes to 8'h5A and is held.
  - On the first change, `stable` must become 8'hA5 with `rise`=8'hA5 on the same cycle.
  - On the second change, `stable` must become 8'h5A with `rise`=8'h5A and `fall`=8'hA5 on one cycle.
- Reset mid-count: `raw`=8'hFF is held for 10 cycles, then `rst_n` is pulsed low asynchronously, between clock edges.
  - `stable` and the counters must clear immediately.
  - After release, `stable` must reach 8'hFF 17 edges after the first sampling edge following release, with no pulse during the reset.
- DEBOUNCE_CYCLES=1: a change on `raw[7]` must reach `stable[7]` at edge k+2.
- Macro undefined: the clean-press stimulus must give the same `stable` behaviour, with `rise` and `fall` constantly 8'h00.
